// File: rtl/tick_delay_sched.sv
// Shared one-shot delay engine: a single down-counter is time-shared among
// NREQ requesters under round-robin arbitration, counting ticks of a chosen timebase.
module tick_delay_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               TICK_1US,
  input  logic               TICK_1MS,
  input  logic               TICK_1S,
  input  logic [NREQ-1:0]    REQ,
  input  logic [2*NREQ-1:0]  REQ_BASE,
  input  logic [CW*NREQ-1:0] REQ_COUNT,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    DONE,
  output logic               BUSY,
  output logic [2:0]         CUR_ID
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t          state, next_state;
  logic [2:0]      cur_id, next_id, arb_id, id_plus1, ptr;
  logic            arb_found, req_cur, sel_tick, busy_d;
  logic [CW-1:0]   counter, sel_count;
  logic [1:0]      base, sel_base;
  logic [NREQ-1:0] gnt_d, done_d;
  int              arb_best, arb_dist;

  // The set request closest at-or-above the pointer (wrapping) wins
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_best  = NREQ;
    arb_dist  = 0;
    for (int i = 0; i < NREQ; i++) begin
      arb_dist = i - int'(ptr);
      if (arb_dist < 0) arb_dist = arb_dist + NREQ;
      if (REQ[i] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        arb_found = 1'b1;
        arb_id    = 3'(i);
      end
    end
  end

  always_comb begin
    req_cur   = 1'b0;
    sel_count = '0;
    sel_base  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cur_id == 3'(i)) begin
        req_cur   = REQ[i];
        sel_count = REQ_COUNT[CW*i +: CW];
        sel_base  = REQ_BASE[2*i +: 2];
      end
    end
  end

  always_comb begin
    case (base)
      2'd0:    sel_tick = TICK_1US;
      2'd1:    sel_tick = TICK_1MS;
      2'd2:    sel_tick = TICK_1S;
      default: sel_tick = 1'b1;
    endcase
  end

  assign id_plus1 = (cur_id == 3'(NREQ-1)) ? 3'd0 : cur_id + 3'd1;

  // Dropping the granted request cancels the job, and takes priority over a final tick
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (arb_found) next_state = ST_LOAD;
      ST_LOAD: begin
        if (!req_cur)               next_state = ST_IDLE;
        else if (sel_count == '0)   next_state = ST_DONE;
        else                        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!req_cur)                               next_state = ST_IDLE;
        else if (sel_tick && (counter == CW'(1)))   next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered alongside it
  always_comb begin
    next_id = cur_id;
    if (state == ST_IDLE)      next_id = arb_id;
    if (next_state == ST_IDLE) next_id = '0;
    busy_d = (next_state != ST_IDLE);
    gnt_d  = busy_d ? (NREQ'(1) << next_id) : '0;
    done_d = (next_state == ST_DONE) ? gnt_d : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      cur_id <= '0;
      GNT    <= '0;
      DONE   <= '0;
      BUSY   <= 1'b0;
    end else begin
      state  <= next_state;
      cur_id <= next_id;
      GNT    <= gnt_d;
      DONE   <= done_d;
      BUSY   <= busy_d;
    end
  end

  assign CUR_ID = cur_id;

  // Counter only decrements while above 1, so it never wraps
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      counter <= '0;
      base    <= '0;
      ptr     <= '0;
    end else begin
      if (state == ST_LOAD) begin
        counter <= sel_count;
        base    <= sel_base;
      end else if ((state == ST_RUN) && req_cur && sel_tick && (counter > CW'(1))) begin
        counter <= counter - CW'(1);
      end
      if ((state != ST_IDLE) && (next_state == ST_IDLE)) ptr <= id_plus1;
    end
  end

endmodule

// File: tb/tb_tick_delay_sched.sv
// Bench for tick_delay_sched: directed table, multi-cycle corner sequences and
// randomized traffic checked against a job-level reference model.
module tb_tick_delay_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk, rst_n, t_us, t_ms, t_s;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_base;
  logic [W*N-1:0] req_count;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [2:0]     cur_id;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit         m_active, m_loaded, m_done;
  int         m_id, m_ptr, m_left;
  logic [1:0] m_base;

  typedef struct {
    logic [N-1:0] req;
    logic [1:0]   base;
    logic [W-1:0] cnt;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [2:0]   id;
  } vec_t;

  vec_t tbl[8];

  tick_delay_sched #(.NREQ(N), .CW(W)) dut (
    .CLK(clk), .RESET_N(rst_n), .TICK_1US(t_us), .TICK_1MS(t_ms), .TICK_1S(t_s),
    .REQ(req), .REQ_BASE(req_base), .REQ_COUNT(req_count),
    .GNT(gnt), .DONE(done), .BUSY(busy), .CUR_ID(cur_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit tick_for(input logic [1:0] b);
    case (b)
      2'd0:    return t_us;
      2'd1:    return t_ms;
      2'd2:    return t_s;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_loaded = 0; m_done = 0;
    m_id = 0; m_ptr = 0; m_left = 0; m_base = 2'd0;
  endtask

  // One clock edge of the job-level view: grant, load, count ticks, finish or cancel
  task automatic model_edge();
    if (!m_active) begin
      for (int k = 0; k < N; k++) begin
        if (!m_active && req[(m_ptr + k) % N]) begin
          m_active = 1; m_loaded = 0; m_done = 0;
          m_id = (m_ptr + k) % N;
        end
      end
    end else if (m_done) begin
      m_active = 0; m_done = 0; m_ptr = (m_id + 1) % N;
    end else if (!req[m_id]) begin
      m_active = 0; m_ptr = (m_id + 1) % N;
    end else if (!m_loaded) begin
      m_left   = int'(req_count[W*m_id +: W]);
      m_base   = req_base[2*m_id +: 2];
      m_loaded = 1;
      if (m_left == 0) m_done = 1;
    end else if (tick_for(m_base)) begin
      if (m_left == 1) m_done = 1;
      else             m_left = m_left - 1;
    end
  endtask

  task automatic apply_stimulus(input bit use_model);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    t_us = 0; t_ms = 0; t_s = 0;
    if (use_model) begin
      check_output("model_gnt",  32'(gnt),    m_active ? (32'd1 << m_id) : 32'd0);
      check_output("model_done", 32'(done),   m_done ? (32'd1 << m_id) : 32'd0);
      check_output("model_busy", 32'(busy),   32'(m_active));
      check_output("model_id",   32'(cur_id), m_active ? 32'(m_id) : 32'd0);
    end
  endtask

  task automatic set_job(input int id, input logic [1:0] b, input logic [W-1:0] c);
    req_base[2*id +: 2]  = b;
    req_count[W*id +: W] = c;
  endtask

  task automatic do_reset();
    rst_n = 0; req = '0; t_us = 0; t_ms = 0; t_s = 0;
    req_base = '0; req_count = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_gnt",  32'(gnt),    32'd0);
    check_output("reset_done", 32'(done),   32'd0);
    check_output("reset_busy", 32'(busy),   32'd0);
    check_output("reset_id",   32'(cur_id), 32'd0);
    rst_n = 1;
  endtask

  initial begin
    int ids[5];
    int times[5];
    int n_seen;
    bit done_seen;

    // Zero-count grant of requester 2, then a count-2 job for requester 0
    tbl[0] = '{4'b0100, 2'd3, 16'd0, 4'b0100, 4'b0000, 1'b1, 3'd2};
    tbl[1] = '{4'b0100, 2'd3, 16'd0, 4'b0100, 4'b0100, 1'b1, 3'd2};
    tbl[2] = '{4'b0000, 2'd3, 16'd0, 4'b0000, 4'b0000, 1'b0, 3'd0};
    tbl[3] = '{4'b0001, 2'd3, 16'd2, 4'b0001, 4'b0000, 1'b1, 3'd0};
    tbl[4] = '{4'b0001, 2'd3, 16'd2, 4'b0001, 4'b0000, 1'b1, 3'd0};
    tbl[5] = '{4'b0001, 2'd3, 16'd2, 4'b0001, 4'b0000, 1'b1, 3'd0};
    tbl[6] = '{4'b0001, 2'd3, 16'd2, 4'b0001, 4'b0001, 1'b1, 3'd0};
    tbl[7] = '{4'b0000, 2'd3, 16'd2, 4'b0000, 4'b0000, 1'b0, 3'd0};

    do_reset();
    for (int r = 0; r < 8; r++) begin
      req = tbl[r].req;
      for (int i = 0; i < N; i++) set_job(i, tbl[r].base, tbl[r].cnt);
      apply_stimulus(0);
      check_output($sformatf("tbl%0d_gnt", r),  32'(gnt),    32'(tbl[r].gnt));
      check_output($sformatf("tbl%0d_done", r), 32'(done),   32'(tbl[r].done));
      check_output($sformatf("tbl%0d_busy", r), 32'(busy),   32'(tbl[r].busy));
      check_output($sformatf("tbl%0d_id", r),   32'(cur_id), 32'(tbl[r].id));
    end

    $display("[TB] single request, base 3, count 10");
    do_reset();
    set_job(0, 2'd3, 16'd10);
    req = 4'b0001;
    for (int k = 1; k <= 13; k++) begin
      apply_stimulus(1);
      if (k == 1)  check_output("single_gnt", 32'(gnt), 32'd1);
      check_output($sformatf("single_done_c%0d", k), 32'(done), (k == 12) ? 32'd1 : 32'd0);
      if (k == 13) check_output("single_busy_low", 32'(busy), 32'd0);
    end

    $display("[TB] reset during RUN");
    do_reset();
    set_job(1, 2'd1, 16'd5);
    req = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      t_ms = (k == 3);
      apply_stimulus(1);
    end
    #3;
    rst_n = 0;
    #1;
    check_output("midreset_gnt",  32'(gnt),    32'd0);
    check_output("midreset_done", 32'(done),   32'd0);
    check_output("midreset_busy", 32'(busy),   32'd0);
    check_output("midreset_id",   32'(cur_id), 32'd0);
    model_reset();
    req = '0;
    @(posedge clk);
    #2;
    rst_n = 1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      t_ms = (k % 3 == 0);
      apply_stimulus(1);
      if (done != '0) done_seen = 1;
    end
    check_output("midreset_no_done", 32'(done_seen), 32'd0);

    $display("[TB] round robin, all held");
    do_reset();
    for (int i = 0; i < N; i++) set_job(i, 2'd3, 16'd1);
    req = 4'b1111;
    n_seen = 0;
    for (int s = 1; s <= 40; s++) begin
      apply_stimulus(1);
      if ((done != '0) && (n_seen < 5)) begin
        for (int i = 0; i < N; i++) if (done[i]) ids[n_seen] = i;
        times[n_seen] = s;
        n_seen++;
      end
    end
    check_output("rr_done_count", 32'(n_seen), 32'd5);
    for (int k = 0; k < n_seen; k++) begin
      check_output($sformatf("rr_order%0d", k), 32'(ids[k]), 32'(k % N));
      if (k > 0) check_output($sformatf("rr_gap%0d", k), 32'(times[k] - times[k-1]), 32'd4);
    end

    $display("[TB] 1 us timebase with foreign ticks");
    do_reset();
    set_job(3, 2'd0, 16'd3);
    req = 4'b1000;
    for (int c = 0; c < 160; c++) begin
      t_us = (c % 50 == 49);
      t_ms = (c % 50 == 20);
      t_s  = (c % 50 == 30);
      apply_stimulus(1);
      check_output($sformatf("tick_done_s%0d", c + 1), 32'(done), (c + 1 == 150) ? 32'd8 : 32'd0);
    end

    $display("[TB] cancel mid-run");
    do_reset();
    set_job(1, 2'd3, 16'd100);
    set_job(2, 2'd3, 16'd2);
    req = 4'b0110;
    for (int s = 1; s <= 68; s++) begin
      apply_stimulus(1);
      check_output("cancel_no_done1", 32'(done[1]), 32'd0);
      if (s == 62) req[1] = 1'b0;
      if (s == 63) check_output("cancel_gnt_clear", 32'(gnt), 32'd0);
      if (s == 64) begin
        check_output("cancel_next_gnt", 32'(gnt),    32'b0100);
        check_output("cancel_next_id",  32'(cur_id), 32'd2);
      end
      if (s == 67) check_output("cancel_next_done", 32'(done), 32'b0100);
    end

    $display("[TB] randomized traffic");
    do_reset();
    for (int i = 0; i < N; i++) set_job(i, 2'($urandom_range(3, 0)), 16'($urandom_range(5, 0)));
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(15, 0) == 0) req[i] = ~req[i];
        if ($urandom_range(7, 0) == 0)
          set_job(i, 2'($urandom_range(3, 0)), 16'($urandom_range(5, 0)));
      end
      t_us = ($urandom_range(3, 0) == 0);
      t_ms = ($urandom_range(3, 0) == 0);
      t_s  = ($urandom_range(3, 0) == 0);
      apply_stimulus(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
